wb_uart_rx_fifo: RTL

Buffering stage directly downstream of the UART receiver's Wishbone byte port.
- Acts as Wishbone master toward the receiver: keeps a strobe asserted and captures each byte on ack into a 2^DEPTH_LOG2-entry FIFO.
- Exposes a pipelined Wishbone slave to the CPU for popping bytes and reading status.
- Flags byte loss when the FIFO is full and drives a non-empty interrupt.

---
 rtl/wb_uart_rx_fifo.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wb_uart_rx_fifo.sv
// Receive-side byte buffer between the UART receiver and the CPU.
// Drains the receiver over a Wishbone master port into a 2^DEPTH_LOG2 x 8 FIFO.
// Serves CPU pops and status reads over a pipelined Wishbone slave port.
// Flags any byte that arrives while the FIFO is full.
module wb_uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       i_wb_clk,
    input  logic       i_wb_rst_n,
    // receiver side (this block is master)
    output logic       o_rx_stb,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_stall,
    input  logic       i_rx_ack,
    // CPU side (this block is slave)
    input  logic       i_wb_stb,
    input  logic       i_wb_addr,
    output logic [7:0] o_wb_data,
    output logic       o_wb_stall,
    output logic       o_wb_ack,
    output logic       o_irq
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [7:0]            mem [DEPTH];

    logic                  rx_stb_q,   rx_stb_d;
    logic                  wb_ack_q,   wb_ack_d;
    logic [7:0]            wb_data_q,  wb_data_d;
    logic                  overflow_q, overflow_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q,   rd_ptr_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
    logic [DEPTH_LOG2:0]   count_q,    count_d;

    logic full, empty, pop, push, status_rd, drop;

    // The stall input carries no information the ack does not already give us.
    logic unused_rx_stall;
    assign unused_rx_stall = i_rx_stall;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A pop only happens on a data read of a non-empty FIFO; a push is allowed
    // when full as long as the same cycle frees a slot.
    assign pop       = i_wb_stb && !i_wb_addr && !empty;
    assign status_rd = i_wb_stb && i_wb_addr;
    assign push      = i_rx_ack && (!full || pop);
    assign drop      = i_rx_ack && !push;

    // Next-state logic for pointers, occupancy, overflow flag and CPU response.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        rx_stb_d   = 1'b1;
        wb_ack_d   = i_wb_stb;
        wb_data_d  = wb_data_q;
        overflow_d = overflow_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;

        if (i_wb_stb) begin
            if (i_wb_addr)
                wb_data_d = {5'b0, overflow_q, full, !empty};
            else if (empty)
                wb_data_d = 8'h00;
            else
                wb_data_d = mem[rd_ptr_q];
        end

        // Clear on status read first so that a same-cycle drop wins.
        if (status_rd) overflow_d = 1'b0;
        if (drop)      overflow_d = 1'b1;

        if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge i_wb_clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!i_wb_rst_n) begin
            rx_stb_q   <= 1'b0;
            wb_ack_q   <= 1'b0;
            wb_data_q  <= 8'h00;
            overflow_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            rx_stb_q   <= rx_stb_d;
            wb_ack_q   <= wb_ack_d;
            wb_data_q  <= wb_data_d;
            overflow_q <= overflow_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage write port.
    always_ff @(posedge i_wb_clk) begin
        // NOTE: storage is not reset; count and pointers alone define which entries are valid.
        if (i_wb_rst_n && push)
            mem[wr_ptr_q] <= i_rx_data;
    end

    assign o_rx_stb   = rx_stb_q;
    assign o_wb_ack   = wb_ack_q;
    assign o_wb_data  = wb_data_q;
    assign o_wb_stall = 1'b0;
    assign o_irq      = !empty;

endmodule
